// File: rtl/clk_skew_monitor_pkg.sv
// Shared types and default constants for the clock skew monitor.
package skew_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT1 = 2'd1,
      WAIT2 = 2'd2
   } state_e;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 8;
   localparam int DEF_TSKEW       = 5;
   localparam int DEF_VIOL_W      = 16;

   localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/clk_skew_monitor_sync_edge_det.sv
// Synchronizes one monitored clock net into clk and flags its rising edges.
module sync_edge_det
   import skew_mon_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/clk_skew_monitor.sv
// Measures clk1/clk2 rising-edge skew in clk cycles, flags skews above TSKEW
// and keeps a saturating violation count.
module clk_skew_monitor
   import skew_mon_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TSKEW       = DEF_TSKEW,
   parameter int VIOL_W      = DEF_VIOL_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk1,
   input  logic              clk2,
   input  logic              enable,
   input  logic              viol_clr,
   output logic              skew_valid,
   output logic [CNT_W-1:0]  skew_cnt,
   output logic              lead2,
   output logic              violation,
   output logic              timeout,
   output logic [VIOL_W-1:0] viol_count
);

   localparam logic [CNT_W-1:0] CNT_LIMIT = '1;
   localparam logic [CNT_W-1:0] TSKEW_C   = CNT_W'(TSKEW);

   logic rise1, rise2;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
      .clk      (clk),
      .reset    (reset),
      .async_in (clk1),
      .rise     (rise1)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
      .clk      (clk),
      .reset    (reset),
      .async_in (clk2),
      .rise     (rise2)
   );

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               valid_q, lead2_q, viol_q, tmo_q;
   logic [CNT_W-1:0]   skew_q;
   logic [VIOL_W-1:0]  vcnt_q;

   logic               rep_d, lead2_d, tmo_d, viol_d;
   logic [CNT_W-1:0]   skew_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         skew_q  <= '0;
         lead2_q <= 1'b0;
         viol_q  <= 1'b0;
         tmo_q   <= 1'b0;
         vcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= rep_d;
         viol_q  <= viol_d;
         tmo_q   <= tmo_d;
         if (rep_d) begin
            skew_q  <= skew_d;
            lead2_q <= lead2_d;
         end
         if (viol_clr)
            vcnt_q <= '0;
         else if (viol_q && vcnt_q != '1)
            vcnt_q <= vcnt_q + 1'b1;
      end
   end

   // A trailing edge landing at cnt == CNT_LIMIT would need CNT_W+1 bits to
   // report, so the timeout wins in that cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (rise1 && !rise2)      state_d = WAIT2;
               else if (rise2 && !rise1) state_d = WAIT1;
            end
            WAIT2: begin
               if (cnt_q == CNT_LIMIT) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (rise2) begin
                  state_d = rise1 ? WAIT2 : IDLE;
                  cnt_d   = '0;
               end else if (rise1) begin
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            WAIT1: begin
               if (cnt_q == CNT_LIMIT) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (rise1) begin
                  state_d = rise2 ? WAIT1 : IDLE;
                  cnt_d   = '0;
               end else if (rise2) begin
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      rep_d   = 1'b0;
      skew_d  = cnt_q + 1'b1;
      lead2_d = 1'b0;
      tmo_d   = 1'b0;
      if (enable) begin
         unique case (state_q)
            IDLE: begin
               if (rise1 && rise2) begin
                  rep_d  = 1'b1;
                  skew_d = '0;
               end
            end
            WAIT2: begin
               if (cnt_q == CNT_LIMIT) tmo_d = 1'b1;
               else if (rise2)         rep_d = 1'b1;
            end
            WAIT1: begin
               if (cnt_q == CNT_LIMIT) tmo_d = 1'b1;
               else if (rise1) begin
                  rep_d   = 1'b1;
                  lead2_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
      viol_d = rep_d && (skew_d > TSKEW_C);
   end

   assign skew_valid = valid_q;
   assign skew_cnt   = skew_q;
   assign lead2      = lead2_q;
   assign violation  = viol_q;
   assign timeout    = tmo_q;
   assign viol_count = vcnt_q;

endmodule
